// File: rtl/button_event_arbiter.sv
// button_event_arbiter
//   Collects one-cycle press pulses from up to NUM_REQ debouncers and delivers
//   them one at a time over a valid/ready handshake. Each requester has a
//   pending latch, so a press made while the consumer is busy is not lost.
//
// Build option:
//   RR_ARB_EN  defined   -> round-robin winner selection (tracks last_grant)
//              undefined -> fixed priority, the lowest pending index wins
//
// Ports:
//   clk_50MHz    in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   req_pulse    in   [NUM_REQ] one-cycle press pulses, bit i = requester i
//   evt_valid    out  an event is offered on evt_id
//   evt_id       out  [IDW] index of the requester being delivered
//   evt_ready    in   consumer accepts when evt_valid && evt_ready
//   pending      out  [NUM_REQ] latched presses not yet granted
//   overrun      out  sticky: a press arrived while already pending
//   clr_overrun  in   synchronous clear of overrun (a new overrun wins)
module button_event_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic               clk_50MHz,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_pulse,
    output logic               evt_valid,
    output logic [IDW-1:0]     evt_id,
    input  logic               evt_ready,
    output logic [NUM_REQ-1:0] pending,
    output logic               overrun,
    input  logic               clr_overrun
);

    localparam int unsigned NR = NUM_REQ;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t             state_q;
    logic               evt_valid_q;
    logic [IDW-1:0]     evt_id_q;
    logic [NUM_REQ-1:0] pending_q;
    logic [NUM_REQ-1:0] pending_d;
    logic               overrun_q;
    logic               overrun_d;
`ifdef RR_ARB_EN
    logic [IDW-1:0]     last_grant_q;
`endif

    logic [IDW-1:0]     win_idx;
    logic               win_found;
    logic               grant;
    logic [NUM_REQ-1:0] grant_vec;
    logic               ovr_set;

    // Winner selection over the registered pending vector.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
`ifdef RR_ARB_EN
        // Scan last_grant+1 .. last_grant+NR, wrapping modulo NR.
        for (int unsigned k = 1; k <= NR; k++) begin
            int unsigned idx;
            idx = 32'(last_grant_q) + k;
            if (idx >= NR) begin
                idx = idx - NR;
            end
            if (!win_found && pending_q[idx]) begin
                win_found = 1'b1;
                win_idx   = IDW'(idx);
            end
        end
`else
        for (int unsigned i = 0; i < NR; i++) begin
            if (!win_found && pending_q[i]) begin
                win_found = 1'b1;
                win_idx   = IDW'(i);
            end
        end
`endif
    end

    always_comb begin
        grant     = (state_q == IDLE) && win_found;
        grant_vec = grant ? (NUM_REQ'(1) << win_idx) : '0;
        // A pulse on the requester being granted this cycle is a fresh press,
        // so the grant clear is applied before the new pulses are OR-ed in.
        pending_d = (pending_q & ~grant_vec) | req_pulse;
        ovr_set   = |(req_pulse & pending_q & ~grant_vec);
        overrun_d = ovr_set | (overrun_q & ~clr_overrun);
    end

    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            evt_valid_q  <= 1'b0;
            evt_id_q     <= '0;
            pending_q    <= '0;
            overrun_q    <= 1'b0;
`ifdef RR_ARB_EN
            last_grant_q <= IDW'(NUM_REQ - 1);
`endif
        end else begin
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        evt_id_q     <= win_idx;
                        evt_valid_q  <= 1'b1;
`ifdef RR_ARB_EN
                        last_grant_q <= win_idx;
`endif
                        state_q      <= OFFER;
                    end
                end
                OFFER: begin
                    // evt_valid is always high here; hold until accepted.
                    if (evt_ready) begin
                        evt_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
            endcase
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_id    = evt_id_q;
    assign pending   = pending_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Self-checking bench for button_event_arbiter (NUM_REQ=4, IDW=2).
// Expected event ids are pushed to a scoreboard when presses are driven and
// popped when a handshake is observed.
module tb_button_event_arbiter;

    logic       clk_50MHz;
    logic       rst_n;
    logic [3:0] req_pulse;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic       evt_ready;
    logic [3:0] pending;
    logic       overrun;
    logic       clr_overrun;

    int n_tests;
    int n_fail;
    int sb[$];

    button_event_arbiter #(
        .NUM_REQ(4),
        .IDW    (2)
    ) dut (
        .clk_50MHz  (clk_50MHz),
        .rst_n      (rst_n),
        .req_pulse  (req_pulse),
        .evt_valid  (evt_valid),
        .evt_id     (evt_id),
        .evt_ready  (evt_ready),
        .pending    (pending),
        .overrun    (overrun),
        .clr_overrun(clr_overrun)
    );

    initial clk_50MHz = 1'b0;
    always #10 clk_50MHz = ~clk_50MHz;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_50MHz);
        #1;
    endtask

    // Let queued events drain, then take the final handshake edge.
    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            step();
            n++;
        end
        check_eq({tag, "_drained"}, 32'(sb.size()), 32'd0);
        step();
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    logic       prev_v;
    logic       prev_rdy;
    logic [1:0] prev_id;
    initial begin
        prev_v   = 1'b0;
        prev_rdy = 1'b0;
        prev_id  = '0;
    end

    always @(negedge clk_50MHz) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (prev_v && !prev_rdy) begin
                check_eq("hold_valid", 32'(evt_valid), 32'd1);
                check_eq("hold_id", 32'(evt_id), 32'(prev_id));
            end
            if (evt_valid && evt_ready) begin
                if (sb.size() == 0) begin
                    check_eq("sb_underflow", 32'(sb.size()), 32'd1);
                end else begin
                    check_eq("evt_id", 32'(evt_id), 32'(sb.pop_front()));
                end
            end
            prev_v   = evt_valid;
            prev_rdy = evt_ready;
            prev_id  = evt_id;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int exp_seq[$];
        int n_re;
        int n;
        n_tests     = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        req_pulse   = '0;
        evt_ready   = 1'b0;
        clr_overrun = 1'b0;
        step();
        step();
        check_eq("rst_valid", 32'(evt_valid), 32'd0);
        check_eq("rst_id", 32'(evt_id), 32'd0);
        check_eq("rst_pending", 32'(pending), 32'd0);
        check_eq("rst_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        step();

        // Single press, 2-edge latency, one-cycle valid.
        evt_ready = 1'b1;
        req_pulse = 4'b0100;
        sb.push_back(2);
        step();
        req_pulse = '0;
        check_eq("sp_pend_e0", 32'(pending), 32'h4);
        check_eq("sp_valid_e0", 32'(evt_valid), 32'd0);
        step();
        check_eq("sp_valid_e1", 32'(evt_valid), 32'd1);
        check_eq("sp_id_e1", 32'(evt_id), 32'd2);
        check_eq("sp_pend_e1", 32'(pending), 32'h0);
        step();
        check_eq("sp_valid_h", 32'(evt_valid), 32'd0);

        // Back-pressure for 10 cycles.
        evt_ready = 1'b0;
        req_pulse = 4'b0010;
        sb.push_back(1);
        step();
        req_pulse = '0;
        step();
        for (int i = 0; i < 10; i++) begin
            check_eq("bp_valid", 32'(evt_valid), 32'd1);
            check_eq("bp_id", 32'(evt_id), 32'd1);
            step();
        end
        evt_ready = 1'b1;
        step();
        check_eq("bp_drop", 32'(evt_valid), 32'd0);

        // Fresh reset so round-robin starts from last_grant = 3.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // All four at once.
        req_pulse = 4'b1111;
        sb.push_back(0);
        sb.push_back(1);
        sb.push_back(2);
        sb.push_back(3);
        step();
        req_pulse = '0;
        check_eq("all_pend", 32'(pending), 32'hf);
        step();
        check_eq("all_first", 32'(evt_id), 32'd0);
        check_eq("all_pend_g", 32'(pending), 32'he);
        drain("all");
        check_eq("all_pend_end", 32'(pending), 32'h0);

        req_pulse = 4'b0011;
        sb.push_back(0);
        sb.push_back(1);
        step();
        req_pulse = '0;
        drain("pair");

        // Requesters 0 and 3 re-press right after each of their grants.
`ifdef RR_ARB_EN
        exp_seq = '{3, 0, 3, 0, 3, 0};
        n_re    = 4;
`else
        exp_seq = '{0, 0, 0, 3};
        n_re    = 2;
`endif
        foreach (exp_seq[j]) sb.push_back(exp_seq[j]);
        req_pulse = 4'b1001;
        step();
        req_pulse = '0;
        for (int k = 0; k < n_re; k++) begin
            n = 0;
            while (!evt_valid && n < 20) begin
                step();
                n++;
            end
            check_eq("fair_wait", 32'(evt_valid), 32'd1);
            req_pulse = 4'(1 << exp_seq[k]);
            step();
            req_pulse = '0;
        end
        drain("fair");

        // Overrun while another event is held.
        evt_ready = 1'b0;
        sb.push_back(1);
        req_pulse = 4'b0010;
        step();
        req_pulse = '0;
        step();
        req_pulse = 4'b0100;
        step();
        check_eq("ovr_first", 32'(overrun), 32'd0);
        req_pulse = 4'b0100;
        step();
        req_pulse = '0;
        check_eq("ovr_set", 32'(overrun), 32'd1);
        check_eq("ovr_pend", 32'(pending), 32'h4);
        check_eq("ovr_id", 32'(evt_id), 32'd1);
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
        check_eq("ovr_clr", 32'(overrun), 32'd0);
        check_eq("ovr_pend_clr", 32'(pending), 32'h4);
        evt_ready = 1'b1;
        sb.push_back(2);
        step();
        req_pulse = 4'b0100;
        step();
        req_pulse = '0;
        check_eq("gp_overrun", 32'(overrun), 32'd0);
        check_eq("gp_pend", 32'(pending), 32'h4);
        check_eq("gp_valid", 32'(evt_valid), 32'd1);
        check_eq("gp_id", 32'(evt_id), 32'd2);
        sb.push_back(2);
        drain("gp");
        check_eq("gp_pend_end", 32'(pending), 32'h0);

        // Clear and new overrun together: set wins.
        evt_ready = 1'b0;
        sb.push_back(3);
        req_pulse = 4'b1000;
        step();
        req_pulse = '0;
        step();
        req_pulse = 4'b0010;
        step();
        req_pulse   = 4'b0010;
        clr_overrun = 1'b1;
        step();
        req_pulse   = '0;
        clr_overrun = 1'b0;
        check_eq("setwin_ovr", 32'(overrun), 32'd1);
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
        check_eq("setwin_clr", 32'(overrun), 32'd0);
        evt_ready = 1'b1;
        sb.push_back(1);
        drain("setwin");

        // Asynchronous reset in the middle of an offer.
        evt_ready = 1'b0;
        sb.push_back(0);
        req_pulse = 4'b0001;
        step();
        req_pulse = '0;
        step();
        req_pulse = 4'b1010;
        step();
        req_pulse = 4'b0010;
        step();
        req_pulse = '0;
        check_eq("mr_pre_valid", 32'(evt_valid), 32'd1);
        check_eq("mr_pre_pend", 32'(pending), 32'ha);
        check_eq("mr_pre_ovr", 32'(overrun), 32'd1);
        rst_n = 1'b0;
        sb.delete();
        #2;
        check_eq("mr_valid", 32'(evt_valid), 32'd0);
        check_eq("mr_id", 32'(evt_id), 32'd0);
        check_eq("mr_pend", 32'(pending), 32'h0);
        check_eq("mr_ovr", 32'(overrun), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        evt_ready = 1'b1;
        sb.push_back(3);
        req_pulse = 4'b1000;
        step();
        req_pulse = '0;
        drain("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
